// File: rtl/xmpl_dsp_pkg.sv
// Shared types and layout constants for the DSP stage sequencer.
package xmpl_dsp_pkg;

  // Sequencer states, 3-bit encoding leaves room for future states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd2,
    ERR  = 3'd3
  } seq_state_e;

  // state_o layout: {state[STATE_FIELD_W-1:0], stage index[IDX_W-1:0]}
  localparam int STATE_FIELD_W = 3;

  // Stage index width; at least one bit even for a single stage.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xmpl_dsp_next_stage.sv
// Combinational priority finder over the active-stage mask: lowest active
// index overall and lowest active index strictly above the current one.
module xmpl_dsp_next_stage
  import xmpl_dsp_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] next_idx_o,
  output logic             next_found_o,
  output logic [IDX_W-1:0] low_idx_o,
  output logic             any_o
);

  // Scan high to low so the last hit is the lowest qualifying index.
  always_comb begin
    next_idx_o   = '0;
    next_found_o = 1'b0;
    low_idx_o    = '0;
    any_o        = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_idx_o = IDX_W'(i);
        any_o     = 1'b1;
        if (IDX_W'(i) > idx_i) begin
          next_idx_o   = IDX_W'(i);
          next_found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xmpl_dsp_seq.sv
// DSP stage sequencer: enables one stage at a time in index order over an
// enable/done handshake, with bypass mask, single-shot/continuous modes,
// per-stage timeout with error capture and a saturating pass counter.
module xmpl_dsp_seq
  import xmpl_dsp_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 1024,
  parameter int TO_W       = 16,
  parameter int LOOP_W     = 16,
  localparam int IDX_W     = idx_width(NUM_STAGES)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           en_i,
  input  logic                           cont_mode_i,
  input  logic [NUM_STAGES-1:0]          bypass_i,
  input  logic [NUM_STAGES-1:0]          stage_done_i,
  output logic [NUM_STAGES-1:0]          en_stage_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [IDX_W-1:0]               err_stage_o,
  output logic [LOOP_W-1:0]              loop_cnt_o,
  output logic [STATE_FIELD_W+IDX_W-1:0] state_o
);

  // Timer value on the last allowed RUN cycle of a stage (unused when TIMEOUT=0).
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TO_W-1:0]         timer_q, timer_d;
  logic [NUM_STAGES-1:0]   bypass_q, bypass_d;
  logic [LOOP_W-1:0]       loop_q, loop_d;
  logic [IDX_W-1:0]        err_stage_q, err_stage_d;
  logic [NUM_STAGES-1:0]   en_stage_q, en_stage_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [NUM_STAGES-1:0]   act_mask;
  logic [IDX_W-1:0]        nxt_idx, low_idx;
  logic                    nxt_found, any_act;
  logic                    cur_done;

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_STAGES'(1) << i;
  endfunction

  function automatic logic [LOOP_W-1:0] sat_inc(input logic [LOOP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // In IDLE the live bypass input decides the first stage; afterwards the latched copy.
  assign act_mask = (state_q == IDLE) ? ~bypass_i : ~bypass_q;
  assign cur_done = |(stage_done_i & onehot(idx_q));

  xmpl_dsp_next_stage #(
    .N     (NUM_STAGES),
    .IDX_W (IDX_W)
  ) u_next (
    .mask_i       (act_mask),
    .idx_i        (idx_q),
    .next_idx_o   (nxt_idx),
    .next_found_o (nxt_found),
    .low_idx_o    (low_idx),
    .any_o        (any_act)
  );

  // Next-state, index, timer and counter decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    bypass_d    = bypass_q;
    loop_d      = loop_q;
    err_stage_d = err_stage_q;
    if (!en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bypass_d = bypass_i;
          loop_d   = '0;
          timer_d  = '0;
          if (any_act) begin
            state_d     = RUN;
            idx_d       = low_idx;
            err_stage_d = '0;
          end else begin
            state_d = DONE;
          end
        end
        RUN: begin
          if (cur_done) begin
            timer_d = '0;
            if (nxt_found) begin
              idx_d = nxt_idx;
            end else if (cont_mode_i) begin
              idx_d  = low_idx;
              loop_d = sat_inc(loop_q);
            end else begin
              state_d = DONE;
            end
          end else if ((TIMEOUT != 0) && (timer_q == TO_LAST)) begin
            state_d     = ERR;
            err_stage_d = idx_q;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DONE, ERR: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    en_stage_d = (state_d == RUN) ? onehot(idx_d) : '0;
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      bypass_q    <= '0;
      loop_q      <= '0;
      err_stage_q <= '0;
      en_stage_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      bypass_q    <= bypass_d;
      loop_q      <= loop_d;
      err_stage_q <= err_stage_d;
      en_stage_q  <= en_stage_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign en_stage_o  = en_stage_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_stage_o = err_stage_q;
  assign loop_cnt_o  = loop_q;
  assign state_o     = {state_q, idx_q};

endmodule

// File: tb/tb_xmpl_dsp_seq.sv
// Directed testbench for the DSP stage sequencer (3 stages, TIMEOUT=8).
module tb_xmpl_dsp_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cont;
  logic [2:0] bypass;
  logic [2:0] sdone;

  logic [2:0]  en_stage, en_stage2;
  logic        done_o, done2;
  logic        err_o, err2;
  logic [1:0]  err_stage, err_stage2;
  logic [15:0] loop_cnt;
  logic [1:0]  loop_cnt2;
  logic [4:0]  state_o, state2;

  int checks = 0;
  int errors = 0;

  xmpl_dsp_seq #(.NUM_STAGES(3), .TIMEOUT(8), .TO_W(16), .LOOP_W(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .cont_mode_i(cont),
    .bypass_i(bypass), .stage_done_i(sdone), .en_stage_o(en_stage),
    .done_o(done_o), .err_o(err_o), .err_stage_o(err_stage),
    .loop_cnt_o(loop_cnt), .state_o(state_o)
  );

  xmpl_dsp_seq #(.NUM_STAGES(3), .TIMEOUT(8), .TO_W(16), .LOOP_W(2)) dut_sat (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .cont_mode_i(cont),
    .bypass_i(bypass), .stage_done_i(sdone), .en_stage_o(en_stage2),
    .done_o(done2), .err_o(err2), .err_stage_o(err_stage2),
    .loop_cnt_o(loop_cnt2), .state_o(state2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cont = 1'b0; bypass = '0; sdone = '0;
    #12;
    checks++;
    if ({en_stage, done_o, err_o, err_stage, loop_cnt, state_o} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b done=%b err=%b es=%0d loop=%0d st=%b required all 0",
               en_stage, done_o, err_o, err_stage, loop_cnt, state_o);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc(2);
    checks++;
    if (state_o !== 5'b000_00 || en_stage !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold: got st=%b en=%b required st=00000 en=000", state_o, en_stage);
    end
  endtask

  task automatic test_single_shot();
    logic [2:0] exp;
    en = 1'b1;
    cyc();
    for (int s = 0; s < 3; s++) begin
      exp = 3'b001 << s;
      checks++;
      if (en_stage !== exp) begin
        errors++;
        $display("FAIL single_enable%0d: got %b required %b", s, en_stage, exp);
      end
      cyc(4);
      sdone = exp;
      cyc();
      sdone = '0;
    end
    checks++;
    if (done_o !== 1'b1 || en_stage !== 3'b000 || state_o[4:2] !== 3'd2) begin
      errors++;
      $display("FAIL single_done: got done=%b en=%b st=%0d required 1 000 2",
               done_o, en_stage, state_o[4:2]);
    end
    en = 1'b0;
    cyc();
    checks++;
    if (done_o !== 1'b0 || state_o[4:2] !== 3'd0) begin
      errors++;
      $display("FAIL single_idle: got done=%b st=%0d required 0 0", done_o, state_o[4:2]);
    end
  endtask

  task automatic test_bypass();
    bypass = 3'b010; sdone = 3'b111; en = 1'b1;
    cyc();
    checks++;
    if (en_stage !== 3'b001) begin
      errors++;
      $display("FAIL bypass_first: got %b required 001", en_stage);
    end
    cyc();
    checks++;
    if (en_stage !== 3'b100) begin
      errors++;
      $display("FAIL bypass_skip: got %b required 100", en_stage);
    end
    cyc();
    checks++;
    if (done_o !== 1'b1 || en_stage !== 3'b000) begin
      errors++;
      $display("FAIL bypass_done: got done=%b en=%b required 1 000", done_o, en_stage);
    end
    en = 1'b0; sdone = '0;
    cyc();
    bypass = 3'b111; en = 1'b1;
    cyc();
    checks++;
    if (done_o !== 1'b1 || en_stage !== 3'b000 || state_o[4:2] !== 3'd2) begin
      errors++;
      $display("FAIL allbypass_done: got done=%b en=%b st=%0d required 1 000 2",
               done_o, en_stage, state_o[4:2]);
    end
    en = 1'b0; bypass = '0;
    cyc();
  endtask

  task automatic test_timeout();
    en = 1'b1;
    cyc();
    sdone = 3'b001;
    cyc();
    sdone = '0;
    cyc(7);
    checks++;
    if (err_o !== 1'b0 || en_stage !== 3'b010) begin
      errors++;
      $display("FAIL timeout_early: got err=%b en=%b required 0 010", err_o, en_stage);
    end
    cyc();
    checks++;
    if (err_o !== 1'b1 || err_stage !== 2'd1 || en_stage !== 3'b000 || state_o[4:2] !== 3'd3) begin
      errors++;
      $display("FAIL timeout_err: got err=%b es=%0d en=%b st=%0d required 1 1 000 3",
               err_o, err_stage, en_stage, state_o[4:2]);
    end
    en = 1'b0;
    cyc();
    checks++;
    if (err_o !== 1'b0 || err_stage !== 2'd1 || state_o[4:2] !== 3'd0) begin
      errors++;
      $display("FAIL timeout_idle: got err=%b es=%0d st=%0d required 0 1 0",
               err_o, err_stage, state_o[4:2]);
    end
  endtask

  task automatic test_continuous();
    logic [2:0] exp;
    cont = 1'b1; sdone = 3'b111; en = 1'b1;
    cyc();
    for (int n = 1; n <= 12; n++) begin
      exp = 3'b001 << ((n - 1) % 3);
      checks++;
      if (en_stage !== exp || loop_cnt !== 16'((n - 1) / 3)) begin
        errors++;
        $display("FAIL cont_cycle%0d: got en=%b loop=%0d required %b %0d",
                 n, en_stage, loop_cnt, exp, (n - 1) / 3);
      end
      cyc();
    end
    checks++;
    if (loop_cnt !== 16'd4 || loop_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL cont_loopcnt: got %0d/%0d required 4/3", loop_cnt, loop_cnt2);
    end
    cont = 1'b0;
    cyc(3);
    checks++;
    if (done_o !== 1'b1 || en_stage !== 3'b000 || loop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL cont_stop: got done=%b en=%b loop=%0d required 1 000 4",
               done_o, en_stage, loop_cnt);
    end
    en = 1'b0; sdone = '0;
    cyc();
  endtask

  task automatic test_abort();
    en = 1'b1;
    cyc();
    checks++;
    if (en_stage !== 3'b001 || loop_cnt !== 16'd0 || err_stage !== 2'd0) begin
      errors++;
      $display("FAIL abort_start: got en=%b loop=%0d es=%0d required 001 0 0",
               en_stage, loop_cnt, err_stage);
    end
    sdone = 3'b001;
    cyc();
    sdone = '0;
    en = 1'b0;
    cyc();
    checks++;
    if (en_stage !== 3'b000 || state_o !== 5'b000_00) begin
      errors++;
      $display("FAIL abort_idle: got en=%b st=%b required 000 00000", en_stage, state_o);
    end
    en = 1'b1;
    cyc();
    checks++;
    if (en_stage !== 3'b001 || state_o !== 5'b001_00) begin
      errors++;
      $display("FAIL abort_restart: got en=%b st=%b required 001 00100", en_stage, state_o);
    end
  endtask

  task automatic test_done_vs_timeout();
    cyc(7);
    sdone = 3'b001;
    cyc();
    sdone = '0;
    checks++;
    if (en_stage !== 3'b010 || err_o !== 1'b0 || state_o !== 5'b001_01) begin
      errors++;
      $display("FAIL done_wins: got en=%b err=%b st=%b required 010 0 00101",
               en_stage, err_o, state_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({en_stage, done_o, err_o, err_stage, loop_cnt, state_o} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b st=%b loop=%0d required all 0",
               en_stage, state_o, loop_cnt);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_bypass();
    test_timeout();
    test_continuous();
    test_abort();
    test_done_vs_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
